// File: rtl/lda_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lda_cmd_master : Avalon-MM master issuing line-draw register sequences      |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module lda_cmd_master #(
  parameter int POLL_MODE = 1,
  parameter int POLL_GAP  = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [8:0]       cmd_x0,
  input  logic [7:0]       cmd_y0,
  input  logic [8:0]       cmd_x1,
  input  logic [7:0]       cmd_y1,
  input  logic [2:0]       cmd_colour,
  output logic [2:0]       avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest,
  output logic             busy,
  output logic             line_done,
  output logic [CNT_W-1:0] lines_done
);

  localparam int c_gap_w = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic c_mode_bit = (POLL_MODE != 0);

  typedef enum logic [3:0] {
    ST_INIT     = 4'd0,
    ST_IDLE     = 4'd1,
    ST_WR_P0    = 4'd2,
    ST_WR_P1    = 4'd3,
    ST_WR_COL   = 4'd4,
    ST_WR_START = 4'd5,
    ST_GAP      = 4'd6,
    ST_RD_STAT  = 4'd7,
    ST_FINISH   = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic [c_gap_w-1:0] gap_q, gap_d;
  logic [CNT_W-1:0]   lines_q, lines_d;
  logic [8:0]         cmd_x0_q, cmd_x0_d, cmd_x1_q, cmd_x1_d;
  logic [7:0]         cmd_y0_q, cmd_y0_d, cmd_y1_q, cmd_y1_d;
  logic [2:0]         cmd_col_q, cmd_col_d;
  logic               avm_write_q, avm_write_d;
  logic               avm_read_q, avm_read_d;
  logic [2:0]         avm_address_q, avm_address_d;
  logic [31:0]        avm_writedata_q, avm_writedata_d;

  logic w_wr_done;
  logic w_rd_done;
  logic w_unused_rd;

  assign w_wr_done   = avm_write_q && !avm_waitrequest;
  assign w_rd_done   = avm_read_q && !avm_waitrequest;
  assign w_unused_rd = ^avm_readdata[31:1];

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    lines_d   = lines_q;
    cmd_x0_d  = cmd_x0_q;
    cmd_y0_d  = cmd_y0_q;
    cmd_x1_d  = cmd_x1_q;
    cmd_y1_d  = cmd_y1_q;
    cmd_col_d = cmd_col_q;

    case (state_q)
      ST_INIT:     if (w_wr_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_x0_d  = cmd_x0;
          cmd_y0_d  = cmd_y0;
          cmd_x1_d  = cmd_x1;
          cmd_y1_d  = cmd_y1;
          cmd_col_d = cmd_colour;
          state_d   = ST_WR_P0;
        end
      end
      ST_WR_P0:    if (w_wr_done) state_d = ST_WR_P1;
      ST_WR_P1:    if (w_wr_done) state_d = ST_WR_COL;
      ST_WR_COL:   if (w_wr_done) state_d = ST_WR_START;
      ST_WR_START: begin
        // In stall mode the slave holds this write until the draw is over
        if (w_wr_done) begin
          if (!c_mode_bit) begin
            state_d = ST_FINISH;
          end else if (POLL_GAP == 0) begin
            state_d = ST_RD_STAT;
          end else begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == c_gap_last) state_d = ST_RD_STAT;
        else                     gap_d   = gap_q + 1'b1;
      end
      ST_RD_STAT: begin
        if (w_rd_done) begin
          if (!avm_readdata[0]) begin
            state_d = ST_FINISH;
          end else if (POLL_GAP == 0) begin
            state_d = ST_RD_STAT;
          end else begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end
      end
      ST_FINISH: begin
        lines_d = lines_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    // Strobes are decoded from the next state so they are valid on entry
    avm_write_d     = 1'b0;
    avm_read_d      = 1'b0;
    avm_address_d   = 3'd0;
    avm_writedata_d = 32'd0;
    case (state_d)
      ST_INIT: begin
        avm_write_d     = 1'b1;
        avm_writedata_d = {31'd0, c_mode_bit};
      end
      ST_WR_P0: begin
        avm_write_d     = 1'b1;
        avm_address_d   = 3'd3;
        avm_writedata_d = {15'd0, cmd_y0_d, cmd_x0_d};
      end
      ST_WR_P1: begin
        avm_write_d     = 1'b1;
        avm_address_d   = 3'd4;
        avm_writedata_d = {15'd0, cmd_y1_d, cmd_x1_d};
      end
      ST_WR_COL: begin
        avm_write_d     = 1'b1;
        avm_address_d   = 3'd5;
        avm_writedata_d = {29'd0, cmd_col_d};
      end
      ST_WR_START: begin
        avm_write_d   = 1'b1;
        avm_address_d = 3'd2;
      end
      ST_RD_STAT: begin
        avm_read_d    = 1'b1;
        avm_address_d = 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_INIT;
      gap_q           <= '0;
      lines_q         <= '0;
      cmd_x0_q        <= '0;
      cmd_y0_q        <= '0;
      cmd_x1_q        <= '0;
      cmd_y1_q        <= '0;
      cmd_col_q       <= '0;
      avm_write_q     <= 1'b0;
      avm_read_q      <= 1'b0;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      gap_q           <= gap_d;
      lines_q         <= lines_d;
      cmd_x0_q        <= cmd_x0_d;
      cmd_y0_q        <= cmd_y0_d;
      cmd_x1_q        <= cmd_x1_d;
      cmd_y1_q        <= cmd_y1_d;
      cmd_col_q       <= cmd_col_d;
      avm_write_q     <= avm_write_d;
      avm_read_q      <= avm_read_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_INIT);
  assign line_done     = (state_q == ST_FINISH);
  assign lines_done    = lines_q;
  assign avm_write     = avm_write_q;
  assign avm_read      = avm_read_q;
  assign avm_address   = avm_address_q;
  assign avm_writedata = avm_writedata_q;

endmodule
`default_nettype wire

// File: tb/tb_lda_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lda_cmd_master : directed bench, poll-mode (CNT_W=4) and stall-mode DUTs |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_lda_cmd_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: poll mode, gap 4, 4-bit counter; index 1: stall mode
  logic [1:0]       rst_n, cmd_valid, cmd_ready, avm_read, avm_write, avm_wait, busy, line_done;
  logic [1:0][8:0]  cmd_x0, cmd_x1;
  logic [1:0][7:0]  cmd_y0, cmd_y1;
  logic [1:0][2:0]  cmd_colour, avm_address;
  logic [1:0][31:0] avm_wdata, avm_rdata;
  logic [3:0]       lines_a;
  logic [15:0]      lines_b;

  int         cyc;
  int         rd_cnt[2], rd_base[2], nbusy[2];
  int         st_cnt[2], st_base[2], st_len[2];
  logic [2:0] st_addr[2];

  int          wn[2], rn[2], dn[2], acc[2], waitcyc[2], stab_err[2], rw_err;
  logic [2:0]  wadr_log[2][256];
  logic [31:0] wdat_log[2][256];
  int          wcyc_log[2][256], rcyc_log[2][256], dcyc_log[2][64];
  logic [1:0]       p_hold, p_wr, p_rd;
  logic [1:0][2:0]  p_adr;
  logic [1:0][31:0] p_dat;

  int n_vec = 0;
  int n_err = 0;
  int wb, rb, db, hb, ab, k;

  // slave model: status busy for nbusy reads, write stall on a chosen address
  assign avm_rdata[0] = {31'd0, (rd_cnt[0] - rd_base[0]) < nbusy[0]};
  assign avm_rdata[1] = {31'd0, (rd_cnt[1] - rd_base[1]) < nbusy[1]};
  assign avm_wait[0]  = avm_write[0] && (avm_address[0] == st_addr[0]) && ((st_cnt[0] - st_base[0]) < st_len[0]);
  assign avm_wait[1]  = avm_write[1] && (avm_address[1] == st_addr[1]) && ((st_cnt[1] - st_base[1]) < st_len[1]);

  lda_cmd_master #(.POLL_MODE(1), .POLL_GAP(4), .CNT_W(4)) u_poll (
    .clk(clk), .reset(rst_n[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_x0(cmd_x0[0]), .cmd_y0(cmd_y0[0]), .cmd_x1(cmd_x1[0]), .cmd_y1(cmd_y1[0]),
    .cmd_colour(cmd_colour[0]),
    .avm_address(avm_address[0]), .avm_read(avm_read[0]), .avm_write(avm_write[0]),
    .avm_writedata(avm_wdata[0]), .avm_readdata(avm_rdata[0]), .avm_waitrequest(avm_wait[0]),
    .busy(busy[0]), .line_done(line_done[0]), .lines_done(lines_a)
  );

  lda_cmd_master #(.POLL_MODE(0), .POLL_GAP(4), .CNT_W(16)) u_stall (
    .clk(clk), .reset(rst_n[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_x0(cmd_x0[1]), .cmd_y0(cmd_y0[1]), .cmd_x1(cmd_x1[1]), .cmd_y1(cmd_y1[1]),
    .cmd_colour(cmd_colour[1]),
    .avm_address(avm_address[1]), .avm_read(avm_read[1]), .avm_write(avm_write[1]),
    .avm_writedata(avm_wdata[1]), .avm_readdata(avm_rdata[1]), .avm_waitrequest(avm_wait[1]),
    .busy(busy[1]), .line_done(line_done[1]), .lines_done(lines_b)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (avm_read[d] && !avm_wait[d])   rd_cnt[d] <= rd_cnt[d] + 1;
      if (avm_write[d] && avm_wait[d])   st_cnt[d] <= st_cnt[d] + 1;
      if (cmd_valid[d] && cmd_ready[d])  acc[d]    <= acc[d] + 1;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (avm_write[d] && !avm_wait[d] && wn[d] < 256) begin
        wadr_log[d][wn[d]] <= avm_address[d];
        wdat_log[d][wn[d]] <= avm_wdata[d];
        wcyc_log[d][wn[d]] <= cyc;
        wn[d]              <= wn[d] + 1;
      end
      if (avm_read[d] && !avm_wait[d] && rn[d] < 256) begin
        rcyc_log[d][rn[d]] <= cyc;
        rn[d]              <= rn[d] + 1;
      end
      if (avm_write[d] && avm_wait[d]) waitcyc[d] <= waitcyc[d] + 1;
      if (line_done[d] && dn[d] < 64) begin
        dcyc_log[d][dn[d]] <= cyc;
        dn[d]              <= dn[d] + 1;
      end
      if (avm_read[d] && avm_write[d]) rw_err <= rw_err + 1;
      if (p_hold[d] && (p_wr[d] != avm_write[d] || p_rd[d] != avm_read[d] ||
                        p_adr[d] != avm_address[d] || p_dat[d] != avm_wdata[d]))
        stab_err[d] <= stab_err[d] + 1;
      p_hold[d] <= (avm_write[d] || avm_read[d]) && avm_wait[d];
      p_wr[d]   <= avm_write[d];
      p_rd[d]   <= avm_read[d];
      p_adr[d]  <= avm_address[d];
      p_dat[d]  <= avm_wdata[d];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    while (!cmd_ready[d] && n < 200) begin
      tick();
      n++;
    end
    chk("ready_timeout", 32'(cmd_ready[d]), 32'd1);
  endtask

  task automatic wait_done(input int d, input int base);
    int n = 0;
    while (dn[d] == base && n < 300) begin
      tick();
      n++;
    end
    chk("line_done_timeout", dn[d] - base, 32'd1);
  endtask

  task automatic send(input int d, input int x0, input int y0, input int x1, input int y1,
                      input int col, input int nb, input bit keep);
    wait_ready(d);
    rd_base[d]    = rd_cnt[d];
    nbusy[d]      = nb;
    cmd_x0[d]     = 9'(x0);
    cmd_y0[d]     = 8'(y0);
    cmd_x1[d]     = 9'(x1);
    cmd_y1[d]     = 8'(y1);
    cmd_colour[d] = 3'(col);
    cmd_valid[d]  = 1'b1;
    tick();
    if (!keep) cmd_valid[d] = 1'b0;
  endtask

  task automatic chk_wr(input int d, input int base, input logic [31:0] p0,
                        input logic [31:0] p1, input logic [31:0] col);
    chk("wr_count",      wn[d] - base, 32'd4);
    chk("wr_p0_addr",    32'(wadr_log[d][base]),     32'd3);
    chk("wr_p0_data",    wdat_log[d][base],          p0);
    chk("wr_p1_addr",    32'(wadr_log[d][base + 1]), 32'd4);
    chk("wr_p1_data",    wdat_log[d][base + 1],      p1);
    chk("wr_col_addr",   32'(wadr_log[d][base + 2]), 32'd5);
    chk("wr_col_data",   wdat_log[d][base + 2],      col);
    chk("wr_start_addr", 32'(wadr_log[d][base + 3]), 32'd2);
    chk("wr_start_data", wdat_log[d][base + 3],      32'd0);
  endtask

  initial begin
    rst_n      = 2'b00;
    cmd_valid  = '0;
    cmd_x0     = '0;
    cmd_y0     = '0;
    cmd_x1     = '0;
    cmd_y1     = '0;
    cmd_colour = '0;
    for (int d = 0; d < 2; d++) begin
      rd_base[d] = 0;
      nbusy[d]   = 0;
      st_base[d] = 0;
      st_len[d]  = 0;
      st_addr[d] = 3'd0;
    end
    repeat (3) tick();

    for (int d = 0; d < 2; d++) begin
      chk("rst_ready",     32'(cmd_ready[d]), 32'd0);
      chk("rst_strobe",    {27'd0, avm_address[d], avm_read[d], avm_write[d]}, 32'd0);
      chk("rst_wdata",     avm_wdata[d], 32'd0);
      chk("rst_busy_done", {30'd0, busy[d], line_done[d]}, 32'd0);
    end
    chk("rst_cnt_a", 32'(lines_a), 32'd0);
    chk("rst_cnt_b", 32'(lines_b), 32'd0);

    rst_n = 2'b11;
    wait_ready(0);
    wait_ready(1);
    chk("mode_count_a", wn[0], 32'd1);
    chk("mode_addr_a",  32'(wadr_log[0][0]), 32'd0);
    chk("mode_data_a",  wdat_log[0][0], 32'h0000_0001);
    chk("mode_count_b", wn[1], 32'd1);
    chk("mode_addr_b",  32'(wadr_log[1][0]), 32'd0);
    chk("mode_data_b",  wdat_log[1][0], 32'h0000_0000);
    chk("mode_no_read", rn[0] + rn[1], 32'd0);
    chk("mode_cnt_a",   32'(lines_a), 32'd0);

    // Poll line: status 1,1,1,0
    wb = wn[0]; rb = rn[0]; db = dn[0];
    send(0, 10, 20, 100, 50, 5, 3, 1'b0);
    wait_done(0, db);
    chk_wr(0, wb, 32'h0000_280A, 32'h0000_6464, 32'h0000_0005);
    chk("l1_reads",  rn[0] - rb, 32'd4);
    chk("l1_gap_first", rcyc_log[0][rb] - wcyc_log[0][wb + 3], 32'd5);
    for (int i = 1; i < 4; i++)
      chk("l1_gap_reads", rcyc_log[0][rb + i] - rcyc_log[0][rb + i - 1], 32'd5);
    chk("l1_done_latency", dcyc_log[0][db] - rcyc_log[0][rb + 3], 32'd1);
    tick();
    chk("l1_count",    32'(lines_a), 32'd1);
    chk("l1_one_pulse", dn[0] - db, 32'd1);
    chk("l1_idle",     {30'd0, busy[0], cmd_ready[0]}, 32'd1);

    // Stall 3 cycles on the addr4 write; status 0 on the first read
    st_addr[0] = 3'd4; st_len[0] = 3; st_base[0] = st_cnt[0];
    hb = waitcyc[0]; wb = wn[0]; rb = rn[0]; db = dn[0];
    send(0, 511, 255, 0, 0, 7, 0, 1'b0);
    wait_done(0, db);
    chk_wr(0, wb, 32'h0001_FFFF, 32'h0000_0000, 32'h0000_0007);
    chk("l2_hold_cycles", waitcyc[0] - hb, 32'd3);
    chk("l2_reads",       rn[0] - rb, 32'd1);
    chk("l2_stable",      stab_err[0], 32'd0);
    tick();
    chk("l2_count", 32'(lines_a), 32'd2);
    st_len[0] = 0;

    // Reset during RD_STAT with cmd_valid held and cmd_x0 changed while busy
    st_addr[0] = 3'd3; st_len[0] = 3; st_base[0] = st_cnt[0];
    wb = wn[0]; ab = acc[0];
    send(0, 1, 2, 3, 4, 1, 1000, 1'b1);
    cmd_x0[0] = 9'h155;
    k = 0;
    while (!avm_read[0] && k < 100) begin
      tick();
      k++;
    end
    chk("l3_read_seen", 32'(avm_read[0]), 32'd1);
    chk("l3_accepts",   acc[0] - ab, 32'd1);
    chk("l3_p0_addr",   32'(wadr_log[0][wb]), 32'd3);
    chk("l3_p0_data",   wdat_log[0][wb], 32'h0000_0401);
    rst_n[0]     = 1'b0;
    cmd_valid[0] = 1'b0;
    tick();
    chk("rstmid_strobe", {27'd0, avm_address[0], avm_read[0], avm_write[0]}, 32'd0);
    chk("rstmid_state",  {29'd0, busy[0], cmd_ready[0], line_done[0]}, 32'd0);
    chk("rstmid_cnt",    32'(lines_a), 32'd0);
    tick();
    st_len[0] = 0;
    wb = wn[0];
    rst_n[0] = 1'b1;
    wait_ready(0);
    chk("reinit_count", wn[0] - wb, 32'd1);
    chk("reinit_addr",  32'(wadr_log[0][wb]), 32'd0);
    chk("reinit_data",  wdat_log[0][wb], 32'h0000_0001);

    // 16 short lines on the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      db = dn[0];
      send(0, i * 16, i, 300 - i, 200, i % 8, 0, 1'b0);
      wait_done(0, db);
      tick();
      chk("wrap_count", 32'(lines_a), 32'((i + 1) % 16));
    end

    // Stall mode: start write held for 30 cycles
    st_addr[1] = 3'd2; st_len[1] = 30; st_base[1] = st_cnt[1];
    hb = waitcyc[1]; wb = wn[1]; db = dn[1];
    send(1, 10, 20, 100, 50, 5, 0, 1'b0);
    wait_done(1, db);
    chk_wr(1, wb, 32'h0000_280A, 32'h0000_6464, 32'h0000_0005);
    chk("b_hold_cycles",   waitcyc[1] - hb, 32'd30);
    chk("b_no_reads",      rn[1], 32'd0);
    chk("b_done_latency",  dcyc_log[1][db] - wcyc_log[1][wb + 3], 32'd1);
    chk("b_stable",        stab_err[1], 32'd0);
    tick();
    chk("b_count", 32'(lines_b), 32'd1);

    chk("a_stable_all", stab_err[0], 32'd0);
    chk("rw_exclusive", rw_err, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit 500000 time units");
    $fatal(1);
  end

endmodule
`default_nettype wire
